// File: rtl/uart_word_tx.sv
`timescale 1ns/1ps
// uart_word_tx: buffers 32-bit words in a small FIFO and serialises 1-4 bytes
// of each word, little-endian, onto a UART line (8N1, idle high).
// Optional feature macro: UART_WORD_TX_PARITY_EN adds an even parity bit (8E1).
module uart_word_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 128000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          fpga_clk,
  input  logic                          fpga_rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_data,
  input  logic [1:0]                    in_bytes,
  output logic                          tx,
  output logic                          busy,
  output logic                          word_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int COUNT_W      = PTR_W + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [COUNT_W-1:0] FULL_CNT   = COUNT_W'(FIFO_DEPTH);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_WORD_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [31:0]          shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 word_done_q, word_done_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [33:0]          mem_q [FIFO_DEPTH];

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic [33:0]          head;
  logic [7:0]           cur_byte;
  logic [2:0]           next_idx;

  assign in_ready   = (count_q != FULL_CNT);
  assign busy       = (count_q != '0) || (state_q != S_IDLE);
  assign tx         = tx_q;
  assign word_done  = word_done_q;
  assign fifo_count = count_q;

  // FIFO bookkeeping: pushes come from the handshake, the FSM pops in LOAD.
  always_comb begin
    push     = in_valid && in_ready;
    pop      = (state_q == S_LOAD);
    head     = mem_q[rd_ptr_q];
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM next state: bit timing, byte sequencing and line level.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = '0;
    bit_idx_d   = bit_idx_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    word_done_d = 1'b0;
    cur_byte    = shift_q[7:0];
    next_idx    = bit_idx_q + 3'd1;
    bit_end     = (baud_cnt_q == CNT_LAST);

    if (state_q != S_IDLE && state_q != S_LOAD) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d    = head[31:0];
        byte_cnt_d = head[33:32];
        bit_idx_d  = 3'd0;
        tx_d       = 1'b0;
        state_d    = S_START;
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = cur_byte[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
            tx_d    = ^cur_byte;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = next_idx;
            tx_d      = cur_byte[next_idx];
          end
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_cnt_q == CNT_PENULT && byte_cnt_q == 2'd0) word_done_d = 1'b1;
        if (bit_end) begin
          if (byte_cnt_q != 2'd0) begin
            shift_d    = {8'h00, shift_q[31:8]};
            byte_cnt_d = byte_cnt_q - 2'd1;
            bit_idx_d  = 3'd0;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else if (count_q != '0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Word storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge fpga_clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_bytes, in_data};
  end

  // State registers; reset forces the line idle and discards everything queued.
  always_ff @(posedge fpga_clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= 3'd0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 32'h0;
      tx_q        <= 1'b1;
      word_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      word_done_q <= word_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
`timescale 1ns/1ps
// tb_uart_word_tx: random words go through the DUT; a PC-side line decoder
// rebuilds the bytes and compares them with a byte queue built from the words.
module tb_uart_word_tx;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD       = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB        = CLK_FREQ / BAUD;
  localparam int BUDGET     = 3000;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic        fpga_clk = 1'b0;
  logic        fpga_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data  = 32'h0;
  logic [1:0]  in_bytes = 2'd0;
  logic        tx;
  logic        busy;
  logic        word_done;
  logic [2:0]  fifo_count;

  int   checks = 0;
  int   errors = 0;
  int   words_expected = 0;
  int   wd_total = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  uart_word_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .fpga_clk  (fpga_clk),
    .fpga_rst  (fpga_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .tx        (tx),
    .busy      (busy),
    .word_done (word_done),
    .fifo_count(fifo_count)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 fpga_clk = ~fpga_clk;

  // Count every word_done pulse seen anywhere in the run.
  always @(negedge fpga_clk) begin
    if (word_done === 1'b1) wd_total++;
  end

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a word (caller is at a negedge), hold it until accepted, then
  // record the bytes the PC side should receive.
  task automatic applyStimulus(input logic [31:0] d, input logic [1:0] n);
    int waited = 0;
    int nb = int'(n);
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = n;
    while (in_ready !== 1'b1 && waited < BUDGET) begin
      @(negedge fpga_clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checkOutput("push_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge fpga_clk);
    for (int k = 0; k <= nb; k++) exp_q.push_back('{b: d[8*k +: 8], last: (k == nb)});
    words_expected++;
    @(negedge fpga_clk);
    in_valid = 1'b0;
    in_data  = $urandom();
    in_bytes = 2'($urandom_range(0, 3));
  endtask

  // Wait for busy to drop; optionally check how many cycles that took.
  task automatic waitIdle(input int expected, input string tag);
    int waited = 0;
    while (busy === 1'b1 && waited < 4 * BUDGET) begin
      @(negedge fpga_clk);
      waited++;
    end
    if (busy !== 1'b0) checkOutput({tag, "_timeout"}, busy, 0);
    else if (expected >= 0) checkOutput(tag, waited, expected);
  endtask

  // Push one word into an idle, empty DUT and check start latency and duration.
  task automatic sendAndTime(input logic [31:0] d, input logic [1:0] n);
    applyStimulus(d, n);
    checkOutput("lat_e0_tx", tx, 1);
    checkOutput("busy_after_push", busy, 1);
    @(negedge fpga_clk);
    checkOutput("lat_e1_tx", tx, 1);
    @(negedge fpga_clk);
    checkOutput("lat_e2_tx", tx, 0);
    checkOutput("popped_count", fifo_count, 0);
    waitIdle(FRAME_BITS * CPB * (int'(n) + 1), "word_cycles");
  endtask

  // PC-side decoder: samples every cycle of a frame, checks each bit is held
  // for exactly CPB cycles and that word_done lands on the final stop cycle.
  task automatic decodeFrame();
    logic [7:0] got = 8'h00;
    logic start_bit = 1'b1, stop_bit = 1'b0, par_bit = 1'b0, first = 1'b0;
    int shape_err = 0, wd_hits = 0, wd_pos = 0;
    bit have_exp;
    exp_t e;
    have_exp = (exp_q.size() != 0);
    if (have_exp) e = exp_q.pop_front();
    else e = '{b: 8'h00, last: 1'b0};
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge fpga_clk);
        if (c == 0) first = tx;
        else if (tx !== first) shape_err++;
        if (word_done === 1'b1) begin
          wd_hits++;
          wd_pos = b * CPB + c;
        end
      end
      if (b == 0) start_bit = first;
      else if (b == FRAME_BITS - 1) stop_bit = first;
      else if (b <= 8) got[b-1] = first;
      else par_bit = first;
    end
    checkOutput("frame_expected", {31'h0, have_exp}, 1);
    checkOutput("rx_byte", {24'h0, got}, {24'h0, e.b});
    checkOutput("start_bit", {31'h0, start_bit}, 0);
    checkOutput("stop_bit", {31'h0, stop_bit}, 1);
    checkOutput("bit_timing", shape_err, 0);
`ifdef UART_WORD_TX_PARITY_EN
    checkOutput("parity_bit", {31'h0, par_bit}, {31'h0, ^e.b});
`endif
    checkOutput("word_done_pos", wd_hits * 1000 + ((wd_hits != 0) ? wd_pos : 0),
                e.last ? 1000 + FRAME_BITS * CPB - 1 : 0);
  endtask

  // Line monitor: a falling edge on an enabled, out-of-reset line starts a frame.
  initial begin : line_monitor
    forever begin
      @(negedge fpga_clk);
      if (mon_en && fpga_rst === 1'b1 && tx === 1'b0) decodeFrame();
    end
  end

  // Hard stop in case something upstream never finishes.
  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed words, random words, FIFO full, mid-frame reset.
  initial begin : main_seq
    int quiet_err;
    int saved_words;
    int wd_before;
    int waited;
    logic [31:0] w6;
    logic [1:0]  n6;

    #2 fpga_rst = 1'b0;
    repeat (3) @(negedge fpga_clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_word_done", word_done, 0);
    fpga_rst = 1'b1;
    quiet_err = 0;
    repeat (20) begin
      @(negedge fpga_clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet_err++;
    end
    checkOutput("post_reset_idle", quiet_err, 0);
    mon_en = 1'b1;

    sendAndTime(32'h000000A5, 2'd0);
    sendAndTime(32'h12345678, 2'd3);
`ifdef UART_WORD_TX_PARITY_EN
    sendAndTime(32'h00000007, 2'd0);
    sendAndTime(32'h00000003, 2'd0);
`endif
    for (int i = 0; i < 6; i++) sendAndTime($urandom(), 2'($urandom_range(0, 3)));

    applyStimulus($urandom(), 2'd0);
    for (int i = 0; i < 4; i++) applyStimulus($urandom(), 2'($urandom_range(0, 3)));
    w6 = $urandom();
    n6 = 2'($urandom_range(0, 3));
    in_valid = 1'b1;
    in_data  = w6;
    in_bytes = n6;
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_count", fifo_count, 4);
    repeat (20) @(negedge fpga_clk);
    checkOutput("full_held_count", fifo_count, 4);
    checkOutput("full_held_ready", in_ready, 0);
    applyStimulus(w6, n6);
    checkOutput("refill_count", fifo_count, 4);
    waitIdle(-1, "fifo_full_drain");

    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom(), 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 40)) @(negedge fpga_clk);
    end
    waitIdle(-1, "burst_drain");

    mon_en = 1'b0;
    saved_words = words_expected;
    applyStimulus(32'hCAFE00A5, 2'd3);
    applyStimulus($urandom(), 2'd1);
    waited = 0;
    while (tx !== 1'b0 && waited < 10) begin
      @(negedge fpga_clk);
      waited++;
    end
    checkOutput("midframe_start_seen", tx, 0);
    repeat (34) @(negedge fpga_clk);
    wd_before = wd_total;
    fpga_rst = 1'b0;
    #1;
    checkOutput("midrst_tx", tx, 1);
    checkOutput("midrst_fifo_count", fifo_count, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_word_done", word_done, 0);
    repeat (3) @(negedge fpga_clk);
    fpga_rst = 1'b1;
    exp_q.delete();
    words_expected = saved_words;
    quiet_err = 0;
    repeat (200) begin
      @(negedge fpga_clk);
      if (tx !== 1'b1 || busy !== 1'b0 || word_done !== 1'b0) quiet_err++;
    end
    checkOutput("midrst_line_quiet", quiet_err, 0);
    checkOutput("midrst_no_word_done", wd_total, wd_before);
    mon_en = 1'b1;

    sendAndTime($urandom(), 2'($urandom_range(0, 3)));

    checkOutput("ref_queue_drained", exp_q.size(), 0);
    checkOutput("word_done_total", wd_total, words_expected);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
